// File: rtl/flow_scheduler.sv
// flow_scheduler: credit-based round-robin packet scheduler.
// Each flow accrues 16.16 fixed-point byte credit every enabled cycle, capped at
// BURST packets. A flow is offered when its credit covers one packet. The offer is
// held until the downstream side accepts it.
// Optional feature: define FLOW_SCHED_STATS_EN to add per-flow grant counters
// on the grant_count output.
module flow_scheduler #(
  parameter int unsigned           N_FLOWS    = 4,
  parameter logic [N_FLOWS*32-1:0] INCREMENTS = {4{32'h0000_1000}},
  parameter logic [N_FLOWS*11-1:0] SIZES      = {4{11'd192}},
  parameter int unsigned           BURST      = 2,
  localparam int unsigned          FLOW_W     = (N_FLOWS > 1) ? $clog2(N_FLOWS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  output logic              sched_valid,
  input  logic              sched_ready,
  output logic [FLOW_W-1:0] sched_flow,
  output logic [10:0]       sched_size
`ifdef FLOW_SCHED_STATS_EN
  ,
  output logic [N_FLOWS*32-1:0] grant_count
`endif
);

  typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [FLOW_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [FLOW_W-1:0] sched_flow_q, sched_flow_d;
  logic [10:0]       sched_size_q, sched_size_d;
  logic [31:0]       credit_q [N_FLOWS];
  logic [31:0]       credit_d [N_FLOWS];

  logic [31:0]        inc_w  [N_FLOWS];
  logic [10:0]        size_w [N_FLOWS];
  logic [31:0]        need_w [N_FLOWS];
  logic [33:0]        cap_w  [N_FLOWS];
  logic [33:0]        acc    [N_FLOWS];
  logic [N_FLOWS-1:0] elig;
  logic               handshake;

  logic [FLOW_W:0]   idx;
  logic              found;
  logic [FLOW_W-1:0] pick;

  assign handshake   = (state_q == OFFER) && sched_ready;
  assign sched_valid = (state_q == OFFER);
  assign sched_flow  = sched_flow_q;
  assign sched_size  = sched_size_q;

  // Unpack per-flow constants and derive eligibility from the registered credit.
  always_comb begin
    for (int i = 0; i < N_FLOWS; i++) begin
      inc_w[i]  = INCREMENTS[i*32 +: 32];
      size_w[i] = SIZES[i*11 +: 11];
      need_w[i] = {5'd0, size_w[i], 16'd0};
      cap_w[i]  = 34'(BURST) * {2'd0, need_w[i]};
      elig[i]   = (credit_q[i] >= need_w[i]);
    end
  end

  // Next credit: add increment, subtract a granted packet, clamp at the cap.
  // Two headroom bits keep the sum from wrapping before the clamp.
  always_comb begin
    for (int i = 0; i < N_FLOWS; i++) begin
      acc[i] = {2'b00, credit_q[i]};
      if (enable) begin
        acc[i] = acc[i] + {2'b00, inc_w[i]};
      end
      if (handshake && (sched_flow_q == FLOW_W'(i))) begin
        acc[i] = acc[i] - {2'b00, need_w[i]};
      end
      credit_d[i] = (acc[i] > cap_w[i]) ? cap_w[i][31:0] : acc[i][31:0];
    end
  end

  // Round-robin search from rr_ptr_q, wrapping modulo N_FLOWS; first eligible wins.
  // NOTE: every combinational output gets a default before any branch so no latch is inferred.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 0; k < N_FLOWS; k++) begin
      idx = {1'b0, rr_ptr_q} + (FLOW_W+1)'(k);
      if (idx >= (FLOW_W+1)'(N_FLOWS)) begin
        idx = idx - (FLOW_W+1)'(N_FLOWS);
      end
      if (!found && elig[idx[FLOW_W-1:0]]) begin
        found = 1'b1;
        pick  = idx[FLOW_W-1:0];
      end
    end
  end

  // FSM next state: start an offer from IDLE, hold it in OFFER until accepted.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    sched_flow_d = sched_flow_q;
    sched_size_d = sched_size_q;
    case (state_q)
      IDLE: begin
        if (enable && found) begin
          state_d      = OFFER;
          sched_flow_d = pick;
          sched_size_d = size_w[pick];
        end
      end
      OFFER: begin
        if (sched_ready) begin
          state_d  = IDLE;
          rr_ptr_d = (sched_flow_q == FLOW_W'(N_FLOWS - 1)) ? '0 : sched_flow_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, offer and credit registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the credit array is reset explicitly because eligibility reads it directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      sched_flow_q <= '0;
      sched_size_q <= '0;
      for (int i = 0; i < N_FLOWS; i++) begin
        credit_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      sched_flow_q <= sched_flow_d;
      sched_size_q <= sched_size_d;
      for (int i = 0; i < N_FLOWS; i++) begin
        credit_q[i] <= credit_d[i];
      end
    end
  end

`ifdef FLOW_SCHED_STATS_EN
  logic [31:0] grant_q [N_FLOWS];
  logic [31:0] grant_d [N_FLOWS];

  // Per-flow handshake count; wraps naturally at 2^32.
  always_comb begin
    for (int i = 0; i < N_FLOWS; i++) begin
      grant_d[i] = grant_q[i];
      if (handshake && (sched_flow_q == FLOW_W'(i))) begin
        grant_d[i] = grant_q[i] + 32'd1;
      end
    end
  end

  // Grant counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_FLOWS; i++) begin
      if (rst) begin
        grant_q[i] <= '0;
      end else begin
        grant_q[i] <= grant_d[i];
      end
    end
  end

  for (genvar g = 0; g < N_FLOWS; g++) begin : g_grant_out
    assign grant_count[g*32 +: 32] = grant_q[g];
  end
`endif

endmodule

// File: tb/tb_flow_scheduler.sv
// tb_flow_scheduler: three scheduler instances driven side by side.
//   A: 4 flows, increments chosen so all flows become eligible in the same cycle.
//   B: 1 flow, 1 byte/cycle, 16-byte packets.
//   C: 2 flows, flow 0 saturates quickly, flow 1 has zero increment.
module tb_flow_scheduler;
  localparam int NI   = 3;
  localparam int MAXF = 4;

  localparam logic [127:0] INC_A  = {32'h0040_0000, 32'h0030_0000, 32'h0020_0000, 32'h0010_0000};
  localparam logic [43:0]  SIZE_A = {11'd256, 11'd192, 11'd128, 11'd64};
  localparam logic [63:0]  INC_C  = {32'h0000_0000, 32'h0040_0000};
  localparam logic [21:0]  SIZE_C = {11'd10, 11'd64};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0] rst_v, en_v, rdy_v;
  logic          valid_a, valid_b, valid_c;
  logic [1:0]    flow_a;
  logic [0:0]    flow_b, flow_c;
  logic [10:0]   size_a, size_b, size_c;
`ifdef FLOW_SCHED_STATS_EN
  logic [127:0]  gc_a;
  logic [31:0]   gc_b;
  logic [63:0]   gc_c;
`endif

  flow_scheduler #(.N_FLOWS(4), .INCREMENTS(INC_A), .SIZES(SIZE_A), .BURST(2)) dut_a (
    .clk(clk), .rst(rst_v[0]), .enable(en_v[0]), .sched_valid(valid_a),
    .sched_ready(rdy_v[0]), .sched_flow(flow_a), .sched_size(size_a)
`ifdef FLOW_SCHED_STATS_EN
    , .grant_count(gc_a)
`endif
  );

  flow_scheduler #(.N_FLOWS(1), .INCREMENTS(32'h0001_0000), .SIZES(11'd16), .BURST(2)) dut_b (
    .clk(clk), .rst(rst_v[1]), .enable(en_v[1]), .sched_valid(valid_b),
    .sched_ready(rdy_v[1]), .sched_flow(flow_b), .sched_size(size_b)
`ifdef FLOW_SCHED_STATS_EN
    , .grant_count(gc_b)
`endif
  );

  flow_scheduler #(.N_FLOWS(2), .INCREMENTS(INC_C), .SIZES(SIZE_C), .BURST(2)) dut_c (
    .clk(clk), .rst(rst_v[2]), .enable(en_v[2]), .sched_valid(valid_c),
    .sched_ready(rdy_v[2]), .sched_flow(flow_c), .sched_size(size_c)
`ifdef FLOW_SCHED_STATS_EN
    , .grant_count(gc_c)
`endif
  );

  // Reference behaviour: credits in 16.16 units, pending offer, round-robin pointer.
  int     m_n      [NI];
  int     m_burst  [NI];
  longint m_inc    [NI][MAXF];
  longint m_size   [NI][MAXF];
  longint m_credit [NI][MAXF];
  bit     m_valid  [NI];
  int     m_flow   [NI];
  int     m_rr     [NI];
  int     m_grants [NI][MAXF];

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  int first_valid_b;
  int hs_flow_a[$];
  int hs_cyc_a[$];
  int hs_cyc_b[$];
  int cnt_c_f0, cnt_c_f1;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic logic dut_valid(input int k);
    case (k)
      0:       return valid_a;
      1:       return valid_b;
      default: return valid_c;
    endcase
  endfunction

  function automatic int dut_flow(input int k);
    case (k)
      0:       return int'(flow_a);
      1:       return int'(flow_b);
      default: return int'(flow_c);
    endcase
  endfunction

  function automatic int dut_size(input int k);
    case (k)
      0:       return int'(size_a);
      1:       return int'(size_b);
      default: return int'(size_c);
    endcase
  endfunction

  // Advance the reference by one clock using the inputs presented for this edge.
  task automatic model_step(input int k);
    bit     hs;
    int     pick;
    longint c, cap;
    if (rst_v[k]) begin
      m_valid[k] = 1'b0;
      m_flow[k]  = 0;
      m_rr[k]    = 0;
      for (int f = 0; f < MAXF; f++) begin
        m_credit[k][f] = 0;
        m_grants[k][f] = 0;
      end
      return;
    end
    hs   = m_valid[k] && rdy_v[k];
    pick = -1;
    if (!m_valid[k] && en_v[k]) begin
      for (int j = 0; j < m_n[k]; j++) begin
        int f;
        f = (m_rr[k] + j) % m_n[k];
        if (pick < 0 && m_credit[k][f] >= m_size[k][f] * 65536) pick = f;
      end
    end
    for (int f = 0; f < m_n[k]; f++) begin
      c = m_credit[k][f] + (en_v[k] ? m_inc[k][f] : 0);
      if (hs && f == m_flow[k]) c = c - m_size[k][f] * 65536;
      cap = m_burst[k] * m_size[k][f] * 65536;
      m_credit[k][f] = (c > cap) ? cap : c;
    end
    if (hs) begin
      m_grants[k][m_flow[k]]++;
      m_valid[k] = 1'b0;
      m_rr[k]    = (m_flow[k] + 1) % m_n[k];
    end else if (pick >= 0) begin
      m_valid[k] = 1'b1;
      m_flow[k]  = pick;
    end
  endtask

  // One clock: advance reference, clock the DUTs, log handshakes, compare outputs.
  task automatic tick();
    bit [NI-1:0] hs_pre;
    int          fl_pre [NI];
    for (int k = 0; k < NI; k++) begin
      hs_pre[k] = dut_valid(k) && rdy_v[k] && !rst_v[k];
      fl_pre[k] = dut_flow(k);
      model_step(k);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (hs_pre[0]) begin
      hs_flow_a.push_back(fl_pre[0]);
      hs_cyc_a.push_back(cyc);
    end
    if (hs_pre[1]) hs_cyc_b.push_back(cyc);
    if (hs_pre[2]) begin
      if (fl_pre[2] == 0) cnt_c_f0++;
      else                cnt_c_f1++;
    end
    for (int k = 0; k < NI; k++) begin
      check($sformatf("valid_%0d", k), dut_valid(k), m_valid[k]);
      if (m_valid[k]) begin
        check($sformatf("flow_%0d", k), dut_flow(k), m_flow[k]);
        check($sformatf("size_%0d", k), dut_size(k), m_size[k][m_flow[k]]);
      end
      if (rst_v[k]) begin
        check($sformatf("rst_flow_%0d", k), dut_flow(k), 0);
        check($sformatf("rst_size_%0d", k), dut_size(k), 0);
      end
    end
  endtask

  task automatic wait_valid(input int k, input string name);
    int n;
    n = 0;
    while (!dut_valid(k) && n < 40) begin
      tick();
      n++;
    end
    check(name, dut_valid(k), 1'b1);
  endtask

  initial begin
    m_n = '{4, 1, 2};
    m_burst = '{2, 2, 2};
    for (int k = 0; k < NI; k++) begin
      for (int f = 0; f < MAXF; f++) begin
        m_inc[k][f] = 0;
        m_size[k][f] = 1;
      end
    end
    m_inc[0][0] = 64'h0010_0000; m_size[0][0] = 64;
    m_inc[0][1] = 64'h0020_0000; m_size[0][1] = 128;
    m_inc[0][2] = 64'h0030_0000; m_size[0][2] = 192;
    m_inc[0][3] = 64'h0040_0000; m_size[0][3] = 256;
    m_inc[1][0] = 64'h0001_0000; m_size[1][0] = 16;
    m_inc[2][0] = 64'h0040_0000; m_size[2][0] = 64;
    m_inc[2][1] = 0;             m_size[2][1] = 10;
    cnt_c_f0 = 0;
    cnt_c_f1 = 0;

    // Reset state.
    rst_v = '1; en_v = '0; rdy_v = '0;
    repeat (3) tick();
    check("rst_valid_a", valid_a, 1'b0);
    check("rst_valid_b", valid_b, 1'b0);
    check("rst_valid_c", valid_c, 1'b0);

    // B: first offer timing and grant spacing. A and C accrue with ready low.
    rst_v = '0; en_v = '1; rdy_v = 3'b010;
    cyc = 0;
    first_valid_b = -1;
    repeat (60) begin
      tick();
      if (first_valid_b < 0 && valid_b) first_valid_b = cyc;
    end
    check("b_first_valid_cycle", first_valid_b, 17);
    check("b_grant_count_60", hs_cyc_b.size(), 3);
    check("b_first_grant_cycle", hs_cyc_b.size() > 0 ? hs_cyc_b[0] : -1, 18);
    for (int i = 1; i < 3; i++) begin
      check($sformatf("b_grant_gap_%0d", i),
            hs_cyc_b.size() > i ? hs_cyc_b[i] - hs_cyc_b[i-1] : -1, 16);
    end
    // A has held flow 0 stalled for 55 cycles.
    check("a_stalled_valid", valid_a, 1'b1);
    check("a_stalled_flow", flow_a, 0);
    check("a_stalled_size", size_a, 64);
    check("a_no_grant_while_stalled", hs_flow_a.size(), 0);

    // A: all credits capped, ready high -> order 0,1,2,3,0 every 2 cycles.
    rdy_v[0] = 1'b1;
    repeat (10) tick();
    check("a_rr_grants", hs_flow_a.size(), 5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("a_rr_order_%0d", i), hs_flow_a.size() > i ? hs_flow_a[i] : -1, i % 4);
      if (i > 0)
        check($sformatf("a_rr_gap_%0d", i),
              hs_cyc_a.size() > i ? hs_cyc_a[i] - hs_cyc_a[i-1] : -1, 2);
    end

    // A: enable dropped while an offer is pending.
    rdy_v[0] = 1'b0;
    wait_valid(0, "a_offer_before_disable");
    en_v[0] = 1'b0;
    repeat (5) tick();
    check("a_offer_held_disabled", valid_a, 1'b1);
    rdy_v[0] = 1'b1;
    tick();
    repeat (6) tick();
    check("a_no_offer_disabled", valid_a, 1'b0);

    // A: reset pulsed during an offer.
    en_v[0] = 1'b1; rdy_v[0] = 1'b0;
    wait_valid(0, "a_offer_before_rst");
    check("a_pending_flow_before_rst", flow_a, 2);
    rst_v[0] = 1'b1;
    tick();
    check("a_valid_after_rst", valid_a, 1'b0);
    rst_v[0] = 1'b0; rdy_v[0] = 1'b1;
    hs_flow_a.delete();
    hs_cyc_a.delete();
    cyc = 0;
    repeat (8) tick();
    check("a_first_flow_after_rst", hs_flow_a.size() > 0 ? hs_flow_a[0] : -1, 0);
    check("a_first_grant_cycle_after_rst", hs_cyc_a.size() > 0 ? hs_cyc_a[0] : -1, 6);

    // C: credit saturation after a long stall, then zero-increment flow never served.
    repeat (10) tick();
    check("c_credit_saturated", dut_c.credit_q[0], 32'h0080_0000);
    check("c_stalled_valid", valid_c, 1'b1);
    check("c_stalled_flow", flow_c, 0);
    rdy_v[2] = 1'b1;
    cnt_c_f0 = 0;
    cnt_c_f1 = 0;
    repeat (20) tick();
    check("c_flow0_grants", cnt_c_f0, 10);
    check("c_flow1_grants", cnt_c_f1, 0);

`ifdef FLOW_SCHED_STATS_EN
    for (int f = 0; f < 4; f++)
      check($sformatf("a_grant_count_%0d", f), gc_a[f*32 +: 32], m_grants[0][f]);
    check("b_grant_count", gc_b, m_grants[1][0]);
    check("c_grant_count_0", gc_c[31:0], m_grants[2][0]);
    check("c_grant_count_1", gc_c[63:32], 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
